// File: rtl/mul_255.sv
// Word-serial N x N unsigned multiplier producing the full 2N-bit product.
// Operand b is consumed W bits per cycle against the full-width a, so one
// operation takes NDIG = N/W accumulate cycles. p holds the last result until
// the next operation completes, keeping the downstream reducer input stable.
module mul_255 #(
  parameter int unsigned N = 255,
  parameter int unsigned W = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned NDIG = N / W;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LastDig = CW'(NDIG - 1);

  if ((N % W) != 0) begin : gen_bad_width
    $error("N must be a multiple of W");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [N+W-1:0] pp;
  logic [2*N-1:0] pp_shift;
  logic [2*N-1:0] acc_sum;

  // Partial product of a against the current low digit of b, aligned to its weight.
  always_comb begin
    pp       = {{W{1'b0}}, a_q} * {{N{1'b0}}, b_q[W-1:0]};
    pp_shift = {{(N-W){1'b0}}, pp} << (W * cnt_q);
    acc_sum  = acc_q + pp_shift;
  end

  // Next-state: accept in idle, accumulate one digit per cycle in run.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        b_d   = b_q >> W;
        cnt_d = cnt_q + 1'b1;
        // Final digit: the sum including this partial product goes straight to p.
        if (cnt_q == LastDig) begin
          p_d     = acc_sum;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mul_255.sv
// Directed and randomized checks for the word-serial 255x255 multiplier.
module tb_mul_255;

  localparam int unsigned N = 255;
  localparam int unsigned W = 17;
  localparam int LAT = 15;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int n_checks;
  int n_fail;

  mul_255 #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom();
    return t[N-1:0];
  endfunction

  // Present operands with start high for exactly one accepting edge.
  task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done (bounded), counting busy cycles seen before done.
  task automatic wait_done(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nbusy++;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (p !== '0) begin n_fail++; $display("FAIL reset_p got %h want 0", p); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_small();
    int n, nb;
    launch(255'd2, 255'd1);
    wait_done(n, nb);
    n_checks++;
    if (n != LAT) begin n_fail++; $display("FAIL small_latency got %0d want %0d", n, LAT); end
    n_checks++;
    if (p !== 510'd2) begin n_fail++; $display("FAIL small_p got %h want 2", p); end
    step();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL small_done_pulse got %b want 0", done); end
  endtask

  task automatic test_max();
    int n, nb, ndone;
    logic [2*N-1:0] exp_p;
    exp_p = {{254{1'b1}}, {255{1'b0}}, 1'b1};
    launch({N{1'b1}}, {N{1'b1}});
    wait_done(n, nb);
    ndone = (done === 1'b1) ? 1 : 0;
    n_checks++;
    if (nb != LAT) begin n_fail++; $display("FAIL max_busy_cycles got %0d want %0d", nb, LAT); end
    n_checks++;
    if (p !== exp_p) begin n_fail++; $display("FAIL max_p got %h want %h", p, exp_p); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 1) begin n_fail++; $display("FAIL max_done_count got %0d want 1", ndone); end
    n_checks++;
    if (p !== exp_p) begin n_fail++; $display("FAIL max_p_hold got %h want %h", p, exp_p); end
  endtask

  task automatic test_zero();
    int n, nb;
    logic [255:0] pat;
    logic [2*N-1:0] prev;
    pat  = {8{32'hdeadbeef}};
    prev = {{254{1'b1}}, {255{1'b0}}, 1'b1};
    launch(pat[N-1:0], '0);
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (p !== prev) begin n_fail++; $display("FAIL zero_hold_prev got %h want %h", p, prev); end
    wait_done(n, nb);
    n_checks++;
    if (p !== '0) begin n_fail++; $display("FAIL zero_b_p got %h want 0", p); end
    launch('0, {N{1'b1}});
    wait_done(n, nb);
    n_checks++;
    if (p !== '0) begin n_fail++; $display("FAIL zero_a_p got %h want 0", p); end
    step();
  endtask

  task automatic test_ignore_start();
    int ndone, at;
    logic [2*N-1:0] got;
    ndone = 0;
    at    = -1;
    got   = '0;
    launch(255'd1000, 255'd3000);
    for (int j = 1; j <= 25; j++) begin
      start = (j == 3 || j == 9);
      a     = 255'd77 + 255'(j);
      b     = {N{1'b1}};
      step();
      if (done === 1'b1) begin
        ndone++;
        if (at < 0) begin at = j; got = p; end
      end
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    n_checks++;
    if (at != LAT) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", at, LAT); end
    n_checks++;
    if (got !== 510'd3000000) begin n_fail++; $display("FAIL ignore_p got %h want 3000000", got); end
  endtask

  task automatic test_reset_mid();
    int n, nb, ndone;
    ndone = 0;
    launch(255'd5, 255'd7);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", done); end
    n_checks++;
    if (p !== '0) begin n_fail++; $display("FAIL midreset_p got %h want 0", p); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL midreset_activity got %0d want 0", ndone); end
    launch(255'd3, 255'd5);
    wait_done(n, nb);
    n_checks++;
    if (p !== 510'd15) begin n_fail++; $display("FAIL midreset_fresh_p got %h want 15", p); end
    step();
  endtask

  task automatic test_back_to_back();
    int n, nb;
    logic [N-1:0] cur_a, cur_b, nxt_a, nxt_b;
    logic [2*N-1:0] exp_p;
    cur_a = rnd255();
    cur_b = rnd255();
    cur_a[N-1] = 1'b1;
    cur_b[N-1] = 1'b1;
    a     = cur_a;
    b     = cur_b;
    start = 1'b1;
    step();
    for (int i = 0; i < 1000; i++) begin
      nxt_a = rnd255();
      nxt_b = rnd255();
      if (i % 4 == 0) begin nxt_a[N-1] = 1'b1; nxt_b[N-1] = 1'b1; end
      if (i % 4 == 1) nxt_a[N-1] = 1'b1;
      if (i % 4 == 2) nxt_b[N-1] = 1'b1;
      a = nxt_a;
      b = nxt_b;
      if (i == 999) start = 1'b0;
      exp_p = {{N{1'b0}}, cur_a} * {{N{1'b0}}, cur_b};
      wait_done(n, nb);
      n_checks++;
      if (n != LAT) begin
        n_fail++;
        $display("FAIL b2b_latency[%0d] got %0d want %0d", i, n, LAT);
      end
      n_checks++;
      if (p !== exp_p) begin
        n_fail++;
        $display("FAIL b2b_p[%0d] got %h want %h", i, p, exp_p);
      end
      cur_a = nxt_a;
      cur_b = nxt_b;
      step();
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_small();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
